seg7_scan_ctrl: RTL and testbench
=================================

Name: seg7_scan_ctrl

Overview:
- Time-multiplexes one shared 4-bit→7-segment decoder across NDIG common-anode digits of the board display.
- Holds a double-buffered NDIG-nibble value and walks a BLANK/DRIVE scan FSM.
- Per slot: presents one nibble to the external decoder, takes its segment pattern back, drives segments and the digit-select anode.
- Sits between the datapath (counters/ALU results) and the display pins.

Parameters:
- NDIG, 4, number of digits scanned; ≥1.
- DWELL, 50000, clk cycles per digit in DRIVE; ≥1.
- BLANK_CYC, 500, clk cycles of all-off before each digit (anti-ghosting); ≥1.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- enable  in  1  1 = scan runs; 0 = display off.
- load  in  1  1-cycle strobe capturing data_in.
- data_in  in  4*NDIG  nibble k = bits [4k+3:4k]; digit 0 = least significant.
- blank_mask  in  NDIG  bit k = 1 keeps digit k dark during its slot.
- dec_nibble  out  4  to shared decoder input, registered.
- seg_in  in  7  active-low pattern returned by shared decoder.
- seg_out  out  7  active-low segments to pins, registered.
- an_n  out  NDIG  active-low one-hot digit select, registered.
- frame_done  out  1  1-cycle pulse at end of last digit's DRIVE.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, idx=0, counters=0.
  - active and pending buffers = 0; pend_valid=0.
  - dec_nibble=0, seg_out=7'h7F, an_n=all 1, frame_done=0.
- States:
  - IDLE: outputs dark. enable=1 → BLANK with idx=0.
  - BLANK: an_n all 1, seg_out=7'h7F. Lasts BLANK_CYC cycles, then → DRIVE.
  - DRIVE: an_n bit idx=0, unless the digit is blanked (then all 1). seg_out <= seg_in every DRIVE cycle (unblanked) or 7'h7F (blanked). Lasts DWELL cycles, then idx ← idx+1 and → BLANK. idx wraps NDIG-1 → 0.
- Enable low:
  - enable=0 in any state → IDLE on the next edge.
  - Outputs go dark on that same edge; idx=0; counters cleared. Mid-frame abort is allowed.
- Decoder feed:
  - dec_nibble is updated on the edge entering BLANK for digit idx, with active[idx].
  - It holds stable through BLANK and DRIVE, so the decoder has ≥BLANK_CYC cycles to settle.
- Segment latency: seg_out in DRIVE reflects seg_in one cycle earlier (1-cycle register latency).
- Output timing: an_n and seg_out change on the same edge as the state transition; never a partial update.
- Double buffer:
  - load=1 → pending ← data_in, pend_valid=1. A repeated load overwrites pending (last wins).
  - Frame boundary = edge entering BLANK with idx=0 (from IDLE or from the wrap). If pend_valid: active ← pending, pend_valid=0.
  - load coincident with a boundary: active ← data_in directly; pend_valid=0.
  - Result: no tearing within a frame.
- frame_done: 1 for exactly one cycle on the edge leaving DRIVE when idx=NDIG-1. Not asserted on enable-abort.
- Timing:
  - Frame length = NDIG*(BLANK_CYC+DWELL) cycles.
  - Counter widths = $clog2 of the max count, minimum 1 bit.
- Blanked digit still consumes its full BLANK+DRIVE time; scan rate is constant.

Optional Feature:
- Macro: SEG7_LZ_SUPPRESS_EN.
- Defined: leading-zero suppression.
  - Digit k (k≥1) is blanked when active nibbles k..NDIG-1 are all 0.
  - Digit 0 is never suppressed; blank_mask is still ORed in.
  - The suppression mask is computed from the active buffer only.
- Undefined: only blank_mask blanks digits; all zeros are displayed.

Test Plan (NDIG=4, DWELL=4, BLANK_CYC=2, frame=24 cycles; bench decoder model is the team 4→7 decoder):
- Reset mid-DRIVE: assert rst_n=0 asynchronously between edges → an_n=4'hF, seg_out=7'h7F, dec_nibble=0 immediately; after release with enable=1, first DRIVE is digit 0.
- Scan order: load data_in=16'h1234, enable=1 → per frame:
  - an_n sequence 1110,1101,1011,0111, each 4 cycles, separated by 2-cycle all-1 gaps.
  - dec_nibble = 4,3,2,1.
  - seg_out = decoder(4),(3),(2),(1).
  - frame_done pulses once every 24 cycles.
- Tearing: load 16'hABCD while idx=2 → digits 2,3 of the current frame still show the old value; next frame shows D,C,B,A. Load coincident with the boundary → new value in that same frame.
- Blank mask: blank_mask=4'b0100 → an_n stays 4'hF and seg_out=7'h7F during the digit-2 slot; frame period unchanged at 24.
- Enable abort: drop enable at cycle 10 → next edge dark, IDLE, no frame_done; re-enable → restarts at digit 0.
- SEG7_LZ_SUPPRESS_EN defined, data_in=16'h0050 → digits 3,2 dark, digits 1,0 show 5,0. data_in=16'h0000 → only digit 0 lit, showing 0.

Source files
------------

// File: rtl/seg7_scan_ctrl.sv
// seg7_scan_ctrl: multiplexes one shared 4->7 decoder across NDIG common-anode digits with a double-buffered value.
// Optional leading-zero suppression is enabled by defining SEG7_LZ_SUPPRESS_EN.
module seg7_scan_ctrl #(
    parameter int NDIG      = 4,
    parameter int DWELL     = 50000,
    parameter int BLANK_CYC = 500
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enable,
    input  logic              load,
    input  logic [4*NDIG-1:0] data_in,
    input  logic [NDIG-1:0]   blank_mask,
    output logic [3:0]        dec_nibble,
    input  logic [6:0]        seg_in,
    output logic [6:0]        seg_out,
    output logic [NDIG-1:0]   an_n,
    output logic              frame_done
);
    localparam int CMAX = DWELL > BLANK_CYC ? DWELL : BLANK_CYC;
    localparam int CW   = CMAX > 1 ? $clog2(CMAX) : 1;
    localparam int IW   = NDIG > 1 ? $clog2(NDIG) : 1;
    localparam logic [CW-1:0] B_LAST = CW'(BLANK_CYC - 1);
    localparam logic [CW-1:0] D_LAST = CW'(DWELL - 1);
    localparam logic [IW-1:0] I_LAST = IW'(NDIG - 1);

    typedef enum logic [1:0] {IDLE, BLANK, DRIVE} state_t;

    state_t            state, state_nx;
    logic [IW-1:0]     idx, idx_nx;
    logic [CW-1:0]     cnt, cnt_nx;
    logic [4*NDIG-1:0] act, act_nx, pend, pend_nx;
    logic              pv, pv_nx, bound, fd_nx;
    logic [3:0]        dec_nx;
    logic [6:0]        seg_nx;
    logic [NDIG-1:0]   an_nx, dark;

`ifdef SEG7_LZ_SUPPRESS_EN
    logic [NDIG-1:0] lz;
    // Walk down from the top digit; a digit is suppressed while everything above and including it is zero.
    always_comb begin : lz_scan
        logic z;
        lz = '0;
        z  = 1'b1;
        for (int k = NDIG - 1; k >= 1; k--) begin
            z     = z & (act[4*k +: 4] == 4'h0);
            lz[k] = z;
        end
    end
    assign dark = blank_mask | lz;
`else
    assign dark = blank_mask;
`endif

    always_comb begin
        state_nx = state;
        idx_nx   = idx;
        cnt_nx   = cnt;
        bound    = 1'b0;
        fd_nx    = 1'b0;
        an_nx    = '1;
        seg_nx   = 7'h7F;
        if (!enable) begin
            state_nx = IDLE;
            idx_nx   = '0;
            cnt_nx   = '0;
        end else begin
            case (state)
                IDLE: begin
                    state_nx = BLANK;
                    idx_nx   = '0;
                    cnt_nx   = '0;
                    bound    = 1'b1;
                end
                BLANK: begin
                    state_nx = cnt == B_LAST ? DRIVE : BLANK;
                    cnt_nx   = cnt == B_LAST ? '0 : cnt + 1'b1;
                end
                DRIVE: begin
                    state_nx = cnt == D_LAST ? BLANK : DRIVE;
                    cnt_nx   = cnt == D_LAST ? '0 : cnt + 1'b1;
                    if (cnt == D_LAST) begin
                        idx_nx = idx == I_LAST ? '0 : idx + 1'b1;
                        bound  = idx == I_LAST;
                        fd_nx  = idx == I_LAST;
                    end
                end
                default: state_nx = IDLE;
            endcase
        end
        if (state_nx == DRIVE && !dark[idx_nx]) begin
            an_nx  = ~(NDIG'(1) << idx_nx);
            seg_nx = seg_in;
        end
        // A load on the frame boundary bypasses pending so it shows in the frame that starts now.
        act_nx  = bound ? (load ? data_in : (pv ? pend : act)) : act;
        pend_nx = load ? data_in : pend;
        pv_nx   = !bound && (load || pv);
        dec_nx  = (state_nx == BLANK && state != BLANK) ? act_nx[4*idx_nx +: 4] : dec_nibble;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            idx        <= '0;
            cnt        <= '0;
            act        <= '0;
            pend       <= '0;
            pv         <= 1'b0;
            dec_nibble <= 4'h0;
            seg_out    <= 7'h7F;
            an_n       <= '1;
            frame_done <= 1'b0;
        end else begin
            state      <= state_nx;
            idx        <= idx_nx;
            cnt        <= cnt_nx;
            act        <= act_nx;
            pend       <= pend_nx;
            pv         <= pv_nx;
            dec_nibble <= dec_nx;
            seg_out    <= seg_nx;
            an_n       <= an_nx;
            frame_done <= fd_nx;
        end
    end
endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// tb_seg7_scan_ctrl: directed plus random scan checks against a frame-position reference model.
module tb_seg7_scan_ctrl;
    localparam int NDIG = 4, DWELL = 4, BLANK_CYC = 2;
    localparam int SLOT = BLANK_CYC + DWELL, FRAME = NDIG * SLOT;

    logic        clk = 1'b0, rst_n = 1'b0, enable = 1'b0, load = 1'b0;
    logic [15:0] data_in = '0;
    logic [3:0]  blank_mask = '0, dec_nibble, an_n;
    logic [6:0]  seg_in, seg_out;
    logic        frame_done;

    int compared = 0, mismatched = 0;

    logic [15:0] m_act = '0, m_pend = '0;
    logic        m_pv = 1'b0, m_scan = 1'b0;
    int          k = 0;
    logic [3:0]  e_an, e_dec;
    logic [6:0]  e_seg;
    logic        e_fd;

    seg7_scan_ctrl #(.NDIG(NDIG), .DWELL(DWELL), .BLANK_CYC(BLANK_CYC)) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .load(load), .data_in(data_in),
        .blank_mask(blank_mask), .dec_nibble(dec_nibble), .seg_in(seg_in),
        .seg_out(seg_out), .an_n(an_n), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] dec7(input logic [3:0] n);
        logic [6:0] t [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
        return t[n];
    endfunction

    always_comb seg_in = dec7(dec_nibble);

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        compared++;
        assert (got === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    // The model places each edge at a position within the frame and derives the outputs from that position.
    task automatic tick();
        int ph, d;
        logic dk;
        logic [3:0] nib;
        @(posedge clk);
        e_an = 4'hF;
        e_seg = 7'h7F;
        e_fd = 1'b0;
        e_dec = 4'h0;
        if (!enable) begin
            m_scan = 1'b0;
            if (load) begin
                m_pend = data_in;
                m_pv = 1'b1;
            end
        end else begin
            if (!m_scan) begin
                m_scan = 1'b1;
                k = 0;
            end else k++;
            ph = k % FRAME;
            d = ph / SLOT;
            if (ph == 0) begin
                m_act = load ? data_in : (m_pv ? m_pend : m_act);
                m_pv = 1'b0;
            end else if (load) begin
                m_pend = data_in;
                m_pv = 1'b1;
            end
            e_fd = k > 0 && ph == 0;
            nib = 4'(m_act >> (4 * d));
            dk = blank_mask[d];
`ifdef SEG7_LZ_SUPPRESS_EN
            if (d > 0 && (m_act >> (4 * d)) == 16'h0) dk = 1'b1;
`endif
            if (ph % SLOT >= BLANK_CYC && !dk) begin
                e_an = ~(4'b1 << d);
                e_seg = dec7(nib);
            end
            e_dec = nib;
        end
        #1;
        chk("an_n", 16'(an_n), 16'(e_an));
        chk("seg_out", 16'(seg_out), 16'(e_seg));
        chk("frame_done", 16'(frame_done), 16'(e_fd));
        if (m_scan) chk("dec_nibble", 16'(dec_nibble), 16'(e_dec));
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("rst_an", 16'(an_n), 16'hF);
        chk("rst_seg", 16'(seg_out), 16'h7F);
        chk("rst_dec", 16'(dec_nibble), 16'h0);
        chk("rst_fd", 16'(frame_done), 16'h0);
        rst_n = 1'b1;
        load = 1'b1;
        data_in = 16'h1234;
        tick();
        load = 1'b0;
        enable = 1'b1;
        repeat (4) tick();
        #1 rst_n = 1'b0;
        #1;
        chk("async_an", 16'(an_n), 16'hF);
        chk("async_seg", 16'(seg_out), 16'h7F);
        chk("async_dec", 16'(dec_nibble), 16'h0);
        chk("async_fd", 16'(frame_done), 16'h0);
        m_act = '0;
        m_pend = '0;
        m_pv = 1'b0;
        m_scan = 1'b0;
        #3 rst_n = 1'b1;
        load = 1'b1;
        data_in = 16'h1234;
        tick();
        load = 1'b0;
        repeat (47) tick();
        while (k % FRAME != 13) tick();
        load = 1'b1;
        data_in = 16'hABCD;
        tick();
        load = 1'b0;
        repeat (30) tick();
        while ((k + 1) % FRAME != 0) tick();
        load = 1'b1;
        data_in = 16'h5678;
        tick();
        load = 1'b0;
        repeat (24) tick();
        blank_mask = 4'b0100;
        repeat (24) tick();
        blank_mask = 4'b0000;
        while (k % FRAME != 9) tick();
        enable = 1'b0;
        tick();
        enable = 1'b1;
        repeat (30) tick();
        load = 1'b1;
        data_in = 16'h0050;
        tick();
        load = 1'b0;
        repeat (48) tick();
        load = 1'b1;
        data_in = 16'h0000;
        tick();
        load = 1'b0;
        repeat (48) tick();
        repeat (400) begin
            enable = $urandom_range(0, 59) != 0;
            load = $urandom_range(0, 7) == 0;
            data_in = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(0, 255)) : 16'($urandom);
            blank_mask = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0;
            tick();
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
